// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Two writeback sources (A = ALU, B = load/multi-cycle unit) each feed a
// small FIFO. A round-robin arbiter drains the FIFOs into a registered
// we3/wa3/wd3 port. A per-register count of outstanding writes drives
// 'pending' so decode can stall on destinations that have not yet committed.

module regfile_write_arbiter_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  // Pointers and occupancy. DEPTH is a power of two, so the pointers wrap for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];
endmodule

module regfile_write_arbiter #(
  parameter int N     = 64,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_valid,
  output logic         a_ready,
  input  logic [4:0]   a_addr,
  input  logic [N-1:0] a_data,
  input  logic         b_valid,
  output logic         b_ready,
  input  logic [4:0]   b_addr,
  input  logic [N-1:0] b_data,
  output logic         we3,
  output logic [4:0]   wa3,
  output logic [N-1:0] wd3,
  output logic [31:0]  pending,
  output logic         idle
);
  localparam int EW = 5 + N;                   // {addr, data}
  localparam int CW = $clog2(DEPTH + 1);       // FIFO occupancy
  localparam int SW = $clog2(2 * DEPTH + 2);   // per-register outstanding writes

  // Index 0 is source A, index 1 is source B.
  logic [1:0]         src_valid, src_ready, push, pop, non_empty;
  logic [1:0][4:0]    src_addr;
  logic [1:0][EW-1:0] src_entry, head;
  logic [1:0][CW-1:0] count;
  logic               rr_b;   // 1: B wins the next tie, 0: A wins

  assign src_valid = {b_valid, a_valid};
  assign src_addr  = {b_addr, a_addr};
  assign src_entry = {{b_addr, b_data}, {a_addr, a_data}};

  // Writes to XZR complete the handshake but are dropped before the FIFO.
  genvar s;
  generate
    for (s = 0; s < 2; s++) begin : g_src
      assign src_ready[s] = !reset && (count[s] != CW'(DEPTH));
      assign push[s]      = src_valid[s] && src_ready[s] && (src_addr[s] != 5'd31);
      assign non_empty[s] = (count[s] != '0);

      regfile_write_arbiter_fifo #(.W(EW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push[s]),
        .push_data (src_entry[s]),
        .pop       (pop[s]),
        .head      (head[s]),
        .count     (count[s])
      );
    end
  endgenerate

  assign a_ready = src_ready[0];
  assign b_ready = src_ready[1];

  // Round-robin grant: a lone non-empty FIFO always wins, ties go to the pointer.
  always_comb begin
    pop = 2'b00;
    if (non_empty[0] && (!non_empty[1] || !rr_b))
      pop[0] = 1'b1;
    else if (non_empty[1])
      pop[1] = 1'b1;
  end

  // Registered write port and round-robin pointer; wa3/wd3 hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3  <= 1'b0;
      wa3  <= '0;
      wd3  <= '0;
      rr_b <= 1'b0;
    end else if (pop[0]) begin
      we3        <= 1'b1;
      {wa3, wd3} <= head[0];
      rr_b       <= 1'b1;
    end else if (pop[1]) begin
      we3        <= 1'b1;
      {wa3, wd3} <= head[1];
      rr_b       <= 1'b0;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Pending scoreboard: +1 per accepted write (both sources may hit the same
  // register in one cycle), -1 when that register's write is on the port.
  genvar r;
  generate
    for (r = 0; r < 31; r++) begin : g_sb
      logic [SW-1:0] cnt;
      logic          inc_a, inc_b, dec;

      assign inc_a = push[0] && (a_addr == 5'(r));
      assign inc_b = push[1] && (b_addr == 5'(r));
      assign dec   = we3 && (wa3 == 5'(r));

      // Outstanding-write counter for this register.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt + SW'(inc_a) + SW'(inc_b) - SW'(dec);
      end

      assign pending[r] = (cnt != '0);
    end
  endgenerate

  assign pending[31] = 1'b0;

  assign idle = !non_empty[0] && !non_empty[1] && !we3;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: single write, tie arbitration,
// back-to-back streaming, XZR drop, same-register collision, async reset.

module tb_regfile_write_arbiter;
  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid;
  logic         a_ready, b_ready;
  logic [4:0]   a_addr, b_addr;
  logic [N-1:0] a_data, b_data;
  logic         we3;
  logic [4:0]   wa3;
  logic [N-1:0] wd3;
  logic [31:0]  pending;
  logic         idle;

  int passed = 0;
  int total  = 0;

  regfile_write_arbiter #(.N(N), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .we3(we3), .wa3(wa3), .wd3(wd3), .pending(pending), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  ai, bi, ncommit;
  bit  a_fire, b_fire, saw_a_full, saw_b_full, stray_we;
  logic [4:0]   exp_addr;
  logic [N-1:0] exp_data;

  initial begin
    reset = 1'b1;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;

    // Reset state
    #2;
    chk("rst_we3", 64'(we3), 64'd0);
    chk("rst_wa3", 64'(wa3), 64'd0);
    chk("rst_wd3", wd3, 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_a_ready", 64'(a_ready), 64'd0);
    chk("rst_b_ready", 64'(b_ready), 64'd0);
    #10 reset = 1'b0;
    #1;
    chk("rel_ready", 64'({a_ready, b_ready}), 64'b11);
    tick();

    // Single A write X5 = 0xDEAD
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'hDEAD;
    tick();
    a_valid = 1'b0;
    chk("t1_acc_we3", 64'(we3), 64'd0);
    chk("t1_acc_pend", 64'(pending), 64'h20);
    chk("t1_acc_idle", 64'(idle), 64'd0);
    tick();
    chk("t1_we3", 64'(we3), 64'd1);
    chk("t1_wa3", 64'(wa3), 64'd5);
    chk("t1_wd3", wd3, 64'hDEAD);
    chk("t1_pend2", 64'(pending), 64'h20);
    tick();
    chk("t1_we3_off", 64'(we3), 64'd0);
    chk("t1_pend_clr", 64'(pending), 64'd0);
    chk("t1_idle", 64'(idle), 64'd1);
    chk("t1_hold", 64'({wa3, wd3[15:0]}), 64'h5DEAD);

    // Tie right after reset: A first
    reset = 1'b1; #2; reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h11;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'h22;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t2_pend", 64'(pending), 64'h6);
    tick();
    chk("t2_g0", 64'({we3, wa3, wd3[7:0]}), {51'd0, 1'b1, 5'd1, 8'h11});
    tick();
    chk("t2_g1", 64'({we3, wa3, wd3[7:0]}), {51'd0, 1'b1, 5'd2, 8'h22});
    chk("t2_pend_a", 64'(pending), 64'h4);
    tick();
    chk("t2_done", 64'({we3, pending}), 64'd0);

    // Both stream 6 writes; sources hold until accepted
    ai = 0; bi = 0; ncommit = 0; saw_a_full = 0; saw_b_full = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      a_valid = (ai < 6); a_addr = 5'(ai + 1);  a_data = 64'h100 + 64'(ai + 1);
      b_valid = (bi < 6); b_addr = 5'(bi + 11); b_data = 64'h200 + 64'(bi + 11);
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      if (a_valid && !a_ready) saw_a_full = 1;
      if (b_valid && !b_ready) saw_b_full = 1;
      tick();
      if (a_fire) ai++;
      if (b_fire) bi++;
      if (we3) begin
        exp_addr = (ncommit % 2 == 0) ? 5'(ncommit / 2 + 1) : 5'(ncommit / 2 + 11);
        exp_data = (ncommit % 2 == 0) ? 64'h100 + 64'(exp_addr) : 64'h200 + 64'(exp_addr);
        chk($sformatf("t3_wa3_%0d", ncommit), 64'(wa3), 64'(exp_addr));
        chk($sformatf("t3_wd3_%0d", ncommit), wd3, exp_data);
        ncommit++;
      end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t3_ncommit", 64'(ncommit), 64'd12);
    chk("t3_accepted", 64'({ai[7:0], bi[7:0]}), 64'h0606);
    chk("t3_ready_drop", 64'({saw_a_full, saw_b_full}), 64'b11);
    chk("t3_end", 64'({idle, pending}), {31'd0, 1'b1, 32'd0});

    // XZR write from B
    b_valid = 1'b1; b_addr = 5'd31; b_data = 64'hFFFF;
    chk("t4_b_ready", 64'(b_ready), 64'd1);
    tick();
    b_valid = 1'b0;
    chk("t4_acc", 64'({we3, idle, pending}), {31'd0, 1'b0, 1'b1, 32'd0});
    tick();
    chk("t4_pop", 64'({we3, idle, pending}), {31'd0, 1'b0, 1'b1, 32'd0});

    // Same register X7 from both sources, pointer back at A
    reset = 1'b1; #2; reset = 1'b0;
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'hA;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 64'hB;
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("t5_pend", 64'(pending), 64'h80);
    tick();
    chk("t5_first", 64'({we3, wa3, wd3[7:0]}), {51'd0, 1'b1, 5'd7, 8'h0A});
    chk("t5_pend1", 64'(pending), 64'h80);
    tick();
    chk("t5_second", 64'({we3, wa3, wd3[7:0]}), {51'd0, 1'b1, 5'd7, 8'h0B});
    chk("t5_pend2", 64'(pending), 64'h80);
    tick();
    chk("t5_done", 64'({we3, pending}), 64'd0);
    chk("t5_final_wd3", wd3, 64'hB);

    // Async reset with writes queued
    a_valid = 1'b1; a_addr = 5'd3; a_data = 64'h33;
    b_valid = 1'b1; b_addr = 5'd4; b_data = 64'h44;
    tick();
    b_valid = 1'b0; a_addr = 5'd8; a_data = 64'h88;
    tick();
    a_valid = 1'b0;
    chk("t6_busy", 64'({we3, idle}), 64'b10);
    #3 reset = 1'b1;
    #1;
    chk("t6_rst", 64'({we3, idle, pending}), {31'd0, 1'b0, 1'b1, 32'd0});
    chk("t6_rst_ready", 64'({a_ready, b_ready}), 64'b00);
    #2 reset = 1'b0;
    stray_we = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we3 || pending != 0 || !idle) stray_we = 1;
    end
    chk("t6_no_stale", 64'(stray_we), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
